// File: rtl/addsub_issue_stage.sv
// Issue stage in front of a combinational add/sub unit: a small request FIFO
// feeds the add_sub operands, and the returned sum is captured with flags and a
// sequence tag into a single valid/ready output slot.
module addsub_issue_stage #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_m,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             as_m,
  output logic [WIDTH-1:0] as_a,
  output logic [WIDTH-1:0] as_b,
  input  logic [WIDTH-1:0] as_s,
  input  logic             as_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_s,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = 1 + 2 * WIDTH;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [EW-1:0]    mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic [TAG_W-1:0] tag_cnt;
  logic [EW-1:0]    head;
  logic             empty;
  logic             push;
  logic             issue;
  logic             ovf_next;

  assign empty    = (count == '0);
  // Only registered occupancy gates acceptance; a pop this cycle gives no credit.
  assign in_ready = (count != FULL_CNT);
  assign push     = in_valid & in_ready;
  assign issue    = !empty & (!out_valid | out_ready);
  assign busy     = !empty | out_valid;
  assign head     = mem[rd_ptr];

  // Present the FIFO head to add_sub; operands are forced to zero when empty.
  always_comb begin
    as_m = 1'b0;
    as_a = '0;
    as_b = '0;
    if (!empty) begin
      as_m = head[EW-1];
      as_a = head[2*WIDTH-1:WIDTH];
      as_b = head[WIDTH-1:0];
    end
  end

  // Signed overflow: for subtract the effective b operand has its sign flipped.
  always_comb begin
    ovf_next = 1'b0;
    if (as_m)
      ovf_next = (as_a[WIDTH-1] != as_b[WIDTH-1]) & (as_s[WIDTH-1] != as_a[WIDTH-1]);
    else
      ovf_next = (as_a[WIDTH-1] == as_b[WIDTH-1]) & (as_s[WIDTH-1] != as_a[WIDTH-1]);
  end

  // Request storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= {in_m, in_a, in_b};
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PW'(1);
      if (issue)
        rd_ptr <= rd_ptr + PW'(1);
      case ({push, issue})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Output slot: capture add_sub result on issue, clear valid on a bare consume.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_s     <= '0;
      out_cout  <= 1'b0;
      out_ovf   <= 1'b0;
      out_zero  <= 1'b0;
      out_tag   <= '0;
      tag_cnt   <= '0;
    end else if (issue) begin
      out_valid <= 1'b1;
      out_s     <= as_s;
      out_cout  <= as_cout;
      out_ovf   <= ovf_next;
      out_zero  <= (as_s == '0);
      out_tag   <= tag_cnt;
      tag_cnt   <= tag_cnt + TAG_W'(1);
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_addsub_issue_stage.sv
// Directed bench for addsub_issue_stage with a behavioural add_sub attached.
module tb_addsub_issue_stage;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       in_m = 1'b0;
  logic [3:0] in_a = '0;
  logic [3:0] in_b = '0;
  logic       as_m;
  logic [3:0] as_a;
  logic [3:0] as_b;
  logic [3:0] as_s;
  logic       as_cout;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [3:0] out_s;
  logic       out_cout;
  logic       out_ovf;
  logic       out_zero;
  logic [3:0] out_tag;
  logic       busy;

  int checks = 0;
  int failures = 0;
  logic [8:0]  sb [$];
  logic [3:0]  exp_tag;
  logic [8:0]  e;
  logic [10:0] exp_v;
  int got;

  always #5 clk = ~clk;

  // External add_sub: a + (b ^ {m}) + m
  assign {as_cout, as_s} = {1'b0, as_a} + {1'b0, as_b ^ {4{as_m}}} + {4'b0, as_m};

  addsub_issue_stage #(.WIDTH(4), .DEPTH(4), .TAG_W(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_m(in_m), .in_a(in_a), .in_b(in_b),
    .as_m(as_m), .as_a(as_a), .as_b(as_b), .as_s(as_s), .as_cout(as_cout),
    .out_valid(out_valid), .out_ready(out_ready), .out_s(out_s), .out_cout(out_cout),
    .out_ovf(out_ovf), .out_zero(out_zero), .out_tag(out_tag), .busy(busy)
  );

  // {s, cout, ovf, zero} from integer arithmetic
  function automatic logic [6:0] model(input logic m, input logic [3:0] a, input logic [3:0] b);
    int sa, sbv, r, u;
    logic [3:0] s;
    sa = int'($signed(a));
    sbv = int'($signed(b));
    r = m ? sa - sbv : sa + sbv;
    u = m ? int'(a) + int'(~b & 4'hf) + 1 : int'(a) + int'(b);
    s = u[3:0];
    return {s, u[4], (r > 7) || (r < -8), s == 4'd0};
  endfunction

  // Drive one cycle of request inputs; record it if it will be accepted.
  task automatic drive(input logic v, input logic m, input logic [3:0] a, input logic [3:0] b);
    in_valid = v; in_m = m; in_a = a; in_b = b;
    if (v && in_ready) sb.push_back({m, a, b});
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    sb.delete();
    exp_tag = '0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({out_valid, out_s, out_cout, out_ovf, out_zero, out_tag, busy, as_m, as_a, as_b, in_ready} !== 24'h1) begin
      failures++;
      $display("FAIL reset_state: got v=%b s=%h tag=%h busy=%b as=%b%h%h rdy=%b expected all zero, in_ready=1",
               out_valid, out_s, out_tag, busy, as_m, as_a, as_b, in_ready);
    end
  endtask

  task automatic test_single();
    do_reset();
    drive(1'b1, 1'b0, 4'b0100, 4'b0011);
    @(negedge clk);
    drive(1'b0, 1'b0, 4'd0, 4'd0);
    checks++;
    if ({out_valid, busy, as_m, as_a, as_b} !== {1'b0, 1'b1, 1'b0, 4'b0100, 4'b0011}) begin
      failures++;
      $display("FAIL single_head: got v=%b busy=%b as=%b/%b/%b expected v=0 busy=1 as=0/0100/0011",
               out_valid, busy, as_m, as_a, as_b);
    end
    @(negedge clk);
    checks++;
    if ({out_valid, out_s, out_cout, out_ovf, out_zero, out_tag} !== {1'b1, 4'b0111, 3'b000, 4'd0}) begin
      failures++;
      $display("FAIL single_result: got v=%b s=%b c=%b o=%b z=%b tag=%0d expected v=1 s=0111 c=0 o=0 z=0 tag=0",
               out_valid, out_s, out_cout, out_ovf, out_zero, out_tag);
    end
    @(negedge clk);
    checks++;
    if ({out_valid, out_s, out_tag, as_a, as_b} !== {1'b1, 4'b0111, 4'd0, 8'h00}) begin
      failures++;
      $display("FAIL single_hold: got v=%b s=%b tag=%0d as_a=%b as_b=%b expected v=1 s=0111 tag=0 as=0",
               out_valid, out_s, out_tag, as_a, as_b);
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({out_valid, out_s, busy} !== {1'b0, 4'b0111, 1'b0}) begin
      failures++;
      $display("FAIL single_consume: got v=%b s=%b busy=%b expected v=0 s=0111 busy=0", out_valid, out_s, busy);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_flags();
    logic [8:0] req [4];
    logic [6:0] expv [4];
    req[0] = {1'b1, 4'b1000, 4'b0011}; expv[0] = {4'b0101, 3'b110};
    req[1] = {1'b1, 4'b0000, 4'b0001}; expv[1] = {4'b1111, 3'b000};
    req[2] = {1'b0, 4'b1111, 4'b0001}; expv[2] = {4'b0000, 3'b101};
    req[3] = {1'b0, 4'b0111, 4'b0001}; expv[3] = {4'b1000, 3'b010};
    do_reset();
    out_ready = 1'b1;
    got = 0;
    for (int cyc = 0; cyc < 10; cyc++) begin
      if (out_valid) begin
        checks++;
        if (got > 3) begin
          failures++;
          $display("FAIL flags_extra: got unexpected result s=%b tag=%0d expected none", out_s, out_tag);
        end else if ({out_s, out_cout, out_ovf, out_zero, out_tag} !== {expv[got], 4'(got)}) begin
          failures++;
          $display("FAIL flags_%0d: got s=%b c=%b o=%b z=%b tag=%0d expected s=%b c=%b o=%b z=%b tag=%0d",
                   got, out_s, out_cout, out_ovf, out_zero, out_tag,
                   expv[got][6:3], expv[got][2], expv[got][1], expv[got][0], got);
        end
        got++;
      end
      if (cyc < 4) drive(1'b1, req[cyc][8], req[cyc][7:4], req[cyc][3:0]);
      else drive(1'b0, 1'b0, 4'd0, 4'd0);
      @(negedge clk);
    end
    checks++;
    if (got != 4) begin
      failures++;
      $display("FAIL flags_count: got %0d results expected 4", got);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (in_ready !== 1'b1) begin
        failures++;
        $display("FAIL bp_ready_%0d: got in_ready=%b expected 1", i, in_ready);
      end
      drive(1'b1, 1'(i), 4'(i + 3), 4'(2 * i + 1));
      @(negedge clk);
    end
    drive(1'b1, 1'b1, 4'hf, 4'hf);
    checks++;
    if ({in_ready, out_valid, out_tag} !== {1'b0, 1'b1, 4'd0}) begin
      failures++;
      $display("FAIL bp_full: got in_ready=%b v=%b tag=%0d expected in_ready=0 v=1 tag=0", in_ready, out_valid, out_tag);
    end
    @(negedge clk);
    drive(1'b0, 1'b0, 4'd0, 4'd0);
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 5; cyc++) begin
      checks++;
      if (!out_valid || sb.size() == 0) begin
        failures++;
        $display("FAIL bp_drain_%0d: got v=%b pending=%0d expected v=1", cyc, out_valid, sb.size());
      end else begin
        e = sb.pop_front();
        exp_v = {model(e[8], e[7:4], e[3:0]), exp_tag};
        if ({out_s, out_cout, out_ovf, out_zero, out_tag} !== exp_v) begin
          failures++;
          $display("FAIL bp_data_%0d: got %b expected %b", cyc, {out_s, out_cout, out_ovf, out_zero, out_tag}, exp_v);
        end
        exp_tag++;
      end
      @(negedge clk);
    end
    checks++;
    if ({out_valid, busy, in_ready} !== 3'b001) begin
      failures++;
      $display("FAIL bp_idle: got v=%b busy=%b in_ready=%b expected 0 0 1", out_valid, busy, in_ready);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_streaming();
    do_reset();
    out_ready = 1'b1;
    got = 0;
    for (int cyc = 0; cyc < 24; cyc++) begin
      if (cyc >= 2 && cyc < 22) begin
        checks++;
        if (!out_valid || sb.size() == 0) begin
          failures++;
          $display("FAIL stream_bubble_%0d: got v=%b expected v=1", cyc, out_valid);
        end else begin
          e = sb.pop_front();
          exp_v = {model(e[8], e[7:4], e[3:0]), exp_tag};
          if ({out_s, out_cout, out_ovf, out_zero, out_tag} !== exp_v) begin
            failures++;
            $display("FAIL stream_data_%0d: got %b expected %b", cyc, {out_s, out_cout, out_ovf, out_zero, out_tag}, exp_v);
          end
          exp_tag++;
          got++;
        end
      end else if (out_valid) begin
        checks++;
        failures++;
        $display("FAIL stream_extra_%0d: got v=1 expected v=0", cyc);
      end
      if (cyc < 20) begin
        checks++;
        if (in_ready !== 1'b1) begin
          failures++;
          $display("FAIL stream_ready_%0d: got in_ready=%b expected 1", cyc, in_ready);
        end
        drive(1'b1, 1'(cyc), 4'(cyc), 4'(~cyc));
      end else drive(1'b0, 1'b0, 4'd0, 4'd0);
      @(negedge clk);
    end
    checks++;
    if (got != 20 || exp_tag != 4'd4) begin
      failures++;
      $display("FAIL stream_count: got %0d results next_tag=%0d expected 20 and 4", got, exp_tag);
    end
  endtask

  task automatic test_reset_midop();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 4'(i), 4'd1);
      @(negedge clk);
    end
    drive(1'b0, 1'b0, 4'd0, 4'd0);
    checks++;
    if ({out_valid, busy, in_ready} !== 3'b111) begin
      failures++;
      $display("FAIL midop_pre: got v=%b busy=%b in_ready=%b expected 1 1 1", out_valid, busy, in_ready);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({out_valid, out_s, out_cout, out_ovf, out_zero, out_tag, busy, as_m, as_a, as_b, in_ready} !== 24'h1) begin
      failures++;
      $display("FAIL midop_reset: got v=%b s=%h tag=%h busy=%b as=%b%h%h rdy=%b expected all zero, in_ready=1",
               out_valid, out_s, out_tag, busy, as_m, as_a, as_b, in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    exp_tag = '0;
    out_ready = 1'b1;
    drive(1'b1, 1'b0, 4'd2, 4'd5);
    @(negedge clk);
    drive(1'b0, 1'b0, 4'd0, 4'd0);
    @(negedge clk);
    checks++;
    if ({out_valid, out_s, out_cout, out_ovf, out_zero, out_tag} !== {1'b1, 4'b0111, 3'b000, 4'd0}) begin
      failures++;
      $display("FAIL midop_after: got v=%b s=%b tag=%0d expected v=1 s=0111 tag=0", out_valid, out_s, out_tag);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 4'(9 + i), 4'(i));
      @(negedge clk);
    end
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 6; cyc++) begin
      checks++;
      if (in_ready !== 1'b1 || !out_valid || sb.size() == 0) begin
        failures++;
        $display("FAIL b2b_flow_%0d: got in_ready=%b v=%b expected 1 1", cyc, in_ready, out_valid);
      end else begin
        e = sb.pop_front();
        exp_v = {model(e[8], e[7:4], e[3:0]), exp_tag};
        if ({out_s, out_cout, out_ovf, out_zero, out_tag} !== exp_v) begin
          failures++;
          $display("FAIL b2b_data_%0d: got %b expected %b", cyc, {out_s, out_cout, out_ovf, out_zero, out_tag}, exp_v);
        end
        exp_tag++;
      end
      drive(1'b1, 1'(cyc), 4'(5 * cyc), 4'(7 - cyc));
      @(negedge clk);
    end
    out_ready = 1'b0;
    drive(1'b1, 1'b0, 4'd6, 4'd6);
    @(negedge clk);
    drive(1'b0, 1'b0, 4'd0, 4'd0);
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL b2b_fill: got in_ready=%b expected 0 after one more push", in_ready);
    end
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 8; cyc++) begin
      if (out_valid) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL b2b_extra: got result tag=%0d expected none", out_tag);
        end else begin
          e = sb.pop_front();
          exp_v = {model(e[8], e[7:4], e[3:0]), exp_tag};
          if ({out_s, out_cout, out_ovf, out_zero, out_tag} !== exp_v) begin
            failures++;
            $display("FAIL b2b_drain_%0d: got %b expected %b", cyc, {out_s, out_cout, out_ovf, out_zero, out_tag}, exp_v);
          end
          exp_tag++;
        end
      end
      @(negedge clk);
    end
    checks++;
    if (sb.size() != 0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_end: got pending=%0d v=%b expected 0 0", sb.size(), out_valid);
    end
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_flags();
    test_backpressure();
    test_streaming();
    test_reset_midop();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
